mem_bus_arbiter: RTL

Sequences and shares the single external memory bus between the instruction-side refill path feeding Fetch and the data-side refill/writeback path. Each requester issues one whole-line burst of BEATS beats. Requesters are selected by round-robin, and a burst is never preempted. The block sits between the two L1 cache controllers and the memory port.

---
 rtl/mem_bus_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Round-robin owner of the shared memory bus: instruction-side line reads vs data-side refills/writebacks.
// Whole-line bursts of BEATS beats, never preempted; one idle turnaround cycle between bursts.
module mem_bus_arbiter #(
  parameter int ADDRESS_WIDTH = 64,
  parameter int DATA_WIDTH    = 64,
  parameter int BEATS         = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_req,
  input  logic [ADDRESS_WIDTH-1:0] i_addr,
  output logic                     i_grant,
  output logic                     i_data_valid,
  output logic                     i_done,
  input  logic                     d_req,
  input  logic [ADDRESS_WIDTH-1:0] d_addr,
  input  logic                     d_we,
  input  logic [DATA_WIDTH-1:0]    d_wdata,
  output logic                     d_wdata_pop,
  output logic                     d_grant,
  output logic                     d_data_valid,
  output logic                     d_done,
  output logic [DATA_WIDTH-1:0]    out_rdata,
  output logic                     bus_req,
  output logic [ADDRESS_WIDTH-1:0] bus_addr,
  output logic                     bus_we,
  input  logic                     bus_ack,
  input  logic                     bus_rvalid,
  input  logic [DATA_WIDTH-1:0]    bus_rdata,
  output logic [DATA_WIDTH-1:0]    bus_wdata,
  input  logic                     bus_wready
);
  localparam int CW = $clog2(BEATS) + 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                   state_q;
  logic                     owner_q;  // 1 = data side
  logic                     last_q;   // side served most recently, 1 = data side
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic                     we_q;
  logic [CW-1:0]            cnt_q;
  logic                     i_grant_q;
  logic                     d_grant_q;
  logic                     bus_req_q;

  logic any_req;
  logic win_d;
  logic beat;
  logic last_beat;

  assign any_req   = i_req | d_req;
  // Data side wins when alone, or on a tie when the instruction side went last.
  assign win_d     = d_req & (~i_req | ~last_q);
  assign beat      = (state_q == DATA) & (we_q ? bus_wready : bus_rvalid);
  assign last_beat = beat & (cnt_q == CW'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      addr_q    <= '0;
      we_q      <= 1'b0;
      cnt_q     <= '0;
      i_grant_q <= 1'b0;
      d_grant_q <= 1'b0;
      bus_req_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q   <= ADDR;
            owner_q   <= win_d;
            last_q    <= win_d;
            addr_q    <= win_d ? d_addr : i_addr;
            we_q      <= win_d & d_we;
            cnt_q     <= '0;
            i_grant_q <= ~win_d;
            d_grant_q <= win_d;
            bus_req_q <= 1'b1;
          end
        end
        ADDR: begin
          if (bus_ack) begin
            state_q   <= DATA;
            bus_req_q <= 1'b0;
          end
        end
        DATA: begin
          if (last_beat) begin
            state_q   <= IDLE;
            i_grant_q <= 1'b0;
            d_grant_q <= 1'b0;
          end else if (beat) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign i_grant      = i_grant_q;
  assign d_grant      = d_grant_q;
  assign bus_req      = bus_req_q;
  assign bus_addr     = addr_q;
  assign bus_we       = we_q;
  assign i_data_valid = beat & ~we_q & ~owner_q;
  assign d_data_valid = beat & ~we_q & owner_q;
  assign d_wdata_pop  = beat & we_q;
  assign i_done       = last_beat & ~owner_q;
  assign d_done       = last_beat & owner_q;
  assign out_rdata    = bus_rdata;
  assign bus_wdata    = d_wdata;
endmodule
